// File: rtl/multiplicador_seq8.sv
// Sequential 8x8 unsigned shift-and-add multiplier driving an external 8-bit ripple adder (Somador8Bits).
// Optional build macro ZERO_SKIP_EN: a zero operand skips the RUN phase and finishes in one cycle.
module multiplicador_seq8 (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  a_in,
  input  logic [7:0]  b_in,
  output logic        ready,
  output logic        done,
  output logic [15:0] produto,
  output logic [7:0]  add_a,
  output logic [7:0]  add_b,
  output logic        add_cin,
  input  logic [7:0]  add_s,
  input  logic        add_cout
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  state;
  logic [7:0]  m;
  logic [7:0]  acc;
  logic [7:0]  q;
  logic [3:0]  cnt;
  logic        zero_op;
  logic [15:0] shifted;

`ifdef ZERO_SKIP_EN
  assign zero_op = (a_in == 8'h00) || (b_in == 8'h00);
`else
  assign zero_op = 1'b0;
`endif

  // Adder result and the old LSB-shifted multiplier form the next {acc,q}; cout is the new top bit.
  assign shifted = {add_cout, add_s, q[7:1]};

  assign add_a   = acc;
  assign add_b   = q[0] ? m : 8'h00;
  assign add_cin = 1'b0;
  assign ready   = (state == IDLE);
  assign done    = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      produto <= 16'h0000;
      acc     <= 8'h00;
      q       <= 8'h00;
      m       <= 8'h00;
      cnt     <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            m   <= a_in;
            q   <= b_in;
            acc <= 8'h00;
            cnt <= 4'd0;
            if (zero_op) begin
              state   <= DONE;
              produto <= 16'h0000;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          {acc, q} <= shifted;
          cnt      <= cnt + 4'd1;
          if (cnt == 4'd7) begin
            state   <= DONE;
            produto <= shifted;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multiplicador_seq8.sv
// Randomized self-checking bench for multiplicador_seq8; models the external adder and checks
// products and latency against plain integer arithmetic.
module tb_multiplicador_seq8;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  a_in;
  logic [7:0]  b_in;
  logic        ready;
  logic        done;
  logic [15:0] produto;
  logic [7:0]  add_a;
  logic [7:0]  add_b;
  logic        add_cin;
  logic [7:0]  add_s;
  logic        add_cout;

  int n_tests = 0;
  int n_fail  = 0;

  multiplicador_seq8 dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a_in     (a_in),
    .b_in     (b_in),
    .ready    (ready),
    .done     (done),
    .produto  (produto),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_cin  (add_cin),
    .add_s    (add_s),
    .add_cout (add_cout)
  );

  // External ripple adder stand-in
  assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {8'h00, add_cin};

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout obs=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_latency(input logic [7:0] a, input logic [7:0] b);
`ifdef ZERO_SKIP_EN
    if (a == 8'h00 || b == 8'h00) return 1;
`endif
    return 9;
  endfunction

  // One accepted operation; optionally pokes start with junk operands while busy.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input bit inject,
                        output bit saw_cout);
    int          lat;
    bit          rdy_bad;
    bit          prod_moved;
    bit          cin_bad;
    logic [15:0] prev_prod;
    logic [15:0] ref_prod;
    ref_prod  = 16'(a) * 16'(b);
    saw_cout  = 1'b0;
    rdy_bad   = 1'b0;
    prod_moved = 1'b0;
    cin_bad   = 1'b0;
    @(negedge clk);
    check("ready_before_start", {31'd0, ready}, 32'd1);
    prev_prod = produto;
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 20) begin
      if (ready) rdy_bad = 1'b1;
      if (produto !== prev_prod) prod_moved = 1'b1;
      if (add_cin !== 1'b0) cin_bad = 1'b1;
      if (add_cout) saw_cout = 1'b1;
      if (inject && ($urandom_range(0, 2) == 0)) begin
        start = 1'b1;
        a_in  = 8'($urandom);
        b_in  = 8'($urandom);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    check("latency", lat, exp_latency(a, b));
    check("produto", {16'd0, produto}, {16'd0, ref_prod});
    check("busy_flags", {29'd0, rdy_bad, prod_moved, cin_bad}, 32'd0);
    @(negedge clk);
    check("done_one_cycle", {30'd0, done, ready}, 32'd1);
    check("produto_hold", {16'd0, produto}, {16'd0, ref_prod});
  endtask

  initial begin
    bit          cout_seen;
    int          n_done;
    int          n_ready;
    int          last_done;
    bit          gap_bad;
    bit          prod_bad;
    logic [7:0]  ra;
    logic [7:0]  rb;

    rst   = 1'b1;
    start = 1'b0;
    a_in  = 8'h00;
    b_in  = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_state", {13'd0, ready, done, add_cin, produto},
          {13'd0, 1'b1, 1'b0, 1'b0, 16'h0000});
    check("reset_adder_drive", {16'd0, add_a, add_b}, 32'd0);
    rst = 1'b0;

    run_op(8'd13, 8'd11, 1'b0, cout_seen);
    run_op(8'd255, 8'd255, 1'b0, cout_seen);
    check("cout_seen_255x255", {31'd0, cout_seen}, 32'd1);
    run_op(8'd0, 8'd200, 1'b0, cout_seen);
    run_op(8'd7, 8'd9, 1'b1, cout_seen);

    // Reset in the middle of a 100x100 run must abort silently
    @(negedge clk);
    a_in = 8'd100;
    b_in = 8'd100;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_state", {14'd0, ready, done, produto}, {14'd0, 1'b1, 1'b0, 16'h0000});
    n_done = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check("abort_no_done", n_done, 0);
    run_op(8'd100, 8'd100, 1'b0, cout_seen);

    // start held high: one operation per 10 cycles
    @(negedge clk);
    a_in = 8'd2;
    b_in = 8'd3;
    start = 1'b1;
    n_done = 0;
    n_ready = 0;
    last_done = -1;
    gap_bad = 1'b0;
    prod_bad = 1'b0;
    for (int t = 1; t <= 40; t++) begin
      @(negedge clk);
      if (ready) n_ready++;
      if (done) begin
        n_done++;
        if (produto !== 16'd6) prod_bad = 1'b1;
        if (last_done >= 0 && (t - last_done) != 10) gap_bad = 1'b1;
        if (last_done < 0 && t != 9) gap_bad = 1'b1;
        last_done = t;
      end
    end
    start = 1'b0;
    check("held_done_count", n_done, 4);
    check("held_ready_count", n_ready, 4);
    check("held_gap_prod", {30'd0, gap_bad, prod_bad}, 32'd0);
    repeat (12) @(negedge clk);

    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      if ($urandom_range(0, 7) == 0) ra = 8'h00;
      if ($urandom_range(0, 7) == 0) rb = 8'h00;
      run_op(ra, rb, 1'b1, cout_seen);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
